// File: rtl/cell_scan_sequencer_if.sv
// Pixel-timing, cell-memory and renderer signals of the cell scan sequencer.
// master = timing generator / memory side, slave = the sequencer.
interface cell_scan_sequencer_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              frame_start;
  logic              line_end;
  logic              pix_en;
  logic              cell_rd_en;
  logic [ADDR_W-1:0] cell_addr;
  logic              cell_data;
  logic [7:0]        color_alive;
  logic [7:0]        color_dead;
  logic [7:0]        color_blank;
  logic [4:0]        x_position;
  logic [4:0]        y_position;
  logic [7:0]        color_in;
  logic              pix_valid;

  modport master (
    output frame_start, line_end, pix_en, cell_data,
           color_alive, color_dead, color_blank,
    input  cell_rd_en, cell_addr, x_position, y_position, color_in, pix_valid
  );

  modport slave (
    input  frame_start, line_end, pix_en, cell_data,
           color_alive, color_dead, color_blank,
    output cell_rd_en, cell_addr, x_position, y_position, color_in, pix_valid
  );
endinterface

// File: rtl/cell_scan_sequencer.sv
// Walks the cell grid in raster order and feeds the circle renderer, 2-cycle latency.
// Optional macro CELL_GRID_LINES_EN: blank the first row/column of every cell.
module cell_scan_sequencer #(
  parameter int unsigned BLOCK_SIZE = 20,
  parameter int unsigned GRID_COLS  = 32,
  parameter int unsigned GRID_ROWS  = 24,
  parameter int unsigned ADDR_W     = 10
) (
  input logic                   clk,
  input logic                   rst_n,
  cell_scan_sequencer_if.slave  bus
);

  localparam int unsigned COL_W = $clog2(GRID_COLS + 1);
  localparam int unsigned ROW_W = $clog2(GRID_ROWS + 1);
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {WAIT_FRAME, SCAN, DONE} state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [CNT_W-1:0]   x_cnt_q, y_cnt_q;

  logic               x_last_c, y_last_c, col_ok_c, pix_ok_c;

  logic               s1_valid_q, rd_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   s1_x_q, s1_y_q;

  logic               pix_valid_q, s2_live_q;
  logic [CNT_W-1:0]   x_pos_q, y_pos_q;
  logic               s2_grid_c;

  assign x_last_c = (x_cnt_q == CNT_W'(BLOCK_SIZE - 1));
  assign y_last_c = (y_cnt_q == CNT_W'(BLOCK_SIZE - 1));
  assign col_ok_c = (col_q < COL_W'(GRID_COLS));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_FRAME;
    else        state_q <= state_d;
  end

  // Next state and the "pixel reads a real cell" decision
  always_comb begin
    state_d  = state_q;
    pix_ok_c = 1'b0;
    if (bus.frame_start) begin
      state_d = SCAN;
    end else if (state_q == SCAN) begin
      pix_ok_c = bus.pix_en && col_ok_c;
      if (bus.line_end && y_last_c && (row_q == ROW_W'(GRID_ROWS - 1)))
        state_d = DONE;
    end
  end

  // Scan counters; line_end clears x/col so it overrides a same-cycle pixel step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else if (bus.frame_start) begin
      col_q   <= '0;
      row_q   <= '0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else if (state_q == SCAN) begin
      if (bus.line_end) begin
        col_q   <= '0;
        x_cnt_q <= '0;
        if (y_last_c) begin
          y_cnt_q <= '0;
          row_q   <= row_q + ROW_W'(1);
        end else begin
          y_cnt_q <= y_cnt_q + CNT_W'(1);
        end
      end else if (pix_ok_c) begin
        if (x_last_c) begin
          x_cnt_q <= '0;
          col_q   <= col_q + COL_W'(1);
        end else begin
          x_cnt_q <= x_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Stage 1: issue the cell read and capture the in-cell offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= bus.pix_en;
      rd_en_q    <= pix_ok_c;
      if (pix_ok_c) begin
        addr_q <= ADDR_W'(row_q) * ADDR_W'(GRID_COLS) + ADDR_W'(col_q);
        s1_x_q <= x_cnt_q;
        s1_y_q <= y_cnt_q;
      end
    end
  end

`ifdef CELL_GRID_LINES_EN
  assign s2_grid_c = (s1_x_q == '0) || (s1_y_q == '0);
`else
  assign s2_grid_c = 1'b0;
`endif

  // Stage 2: position and colour select; blank pixels report offset 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q <= 1'b0;
      s2_live_q   <= 1'b0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
    end else begin
      pix_valid_q <= s1_valid_q;
      s2_live_q   <= rd_en_q && !s2_grid_c;
      if (rd_en_q) begin
        x_pos_q <= s1_x_q;
        y_pos_q <= s1_y_q;
      end else begin
        x_pos_q <= '0;
        y_pos_q <= '0;
      end
    end
  end

  assign bus.cell_rd_en = rd_en_q;
  assign bus.cell_addr  = addr_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.x_position = x_pos_q;
  assign bus.y_position = y_pos_q;

  // cell_data arrives in the stage-2 cycle, so the final colour mux follows it directly
  assign bus.color_in = !pix_valid_q ? 8'h00 :
                        s2_live_q    ? (bus.cell_data ? bus.color_alive : bus.color_dead) :
                                       bus.color_blank;

endmodule

// File: tb/tb_cell_scan_sequencer.sv
// Directed bench for cell_scan_sequencer; cell memory model marks even addresses alive.
// Expectations follow CELL_GRID_LINES_EN when the bench is built with it.
module tb_cell_scan_sequencer;

  localparam int unsigned BS = 20;
  localparam int unsigned GC = 32;
  localparam int unsigned GR = 24;
  localparam int unsigned AW = 10;

  localparam logic [7:0] C_ALIVE = 8'hA5;
  localparam logic [7:0] C_DEAD  = 8'h3C;
  localparam logic [7:0] C_BLANK = 8'h11;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cell_scan_sequencer_if #(.ADDR_W(AW)) bus ();

  cell_scan_sequencer #(
    .BLOCK_SIZE(BS), .GRID_COLS(GC), .GRID_ROWS(GR), .ADDR_W(AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Synchronous cell memory: data valid the cycle after the read strobe
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.cell_data <= 1'b0;
    else        bus.cell_data <= bus.cell_rd_en & ~bus.cell_addr[0];
  end

  function automatic logic [7:0] exp_color(input int x, input int y, input logic alive);
`ifdef CELL_GRID_LINES_EN
    if (x == 0 || y == 0) return C_BLANK;
`endif
    return alive ? C_ALIVE : C_DEAD;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.frame_start = 1'b0; bus.line_end = 1'b0; bus.pix_en = 1'b0;
    bus.color_alive = C_ALIVE; bus.color_dead = C_DEAD; bus.color_blank = C_BLANK;
    repeat (3) step();
    checks++; if (bus.cell_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", bus.cell_rd_en); end
    checks++; if (bus.cell_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.cell_addr); end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got=%b exp=0", bus.pix_valid); end
    checks++; if (bus.x_position !== 5'd0) begin errors++; $display("FAIL reset_x got=%0d exp=0", bus.x_position); end
    checks++; if (bus.y_position !== 5'd0) begin errors++; $display("FAIL reset_y got=%0d exp=0", bus.y_position); end
    checks++; if (bus.color_in !== 8'h00) begin errors++; $display("FAIL reset_color got=%h exp=00", bus.color_in); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_wait_frame();
    bus.pix_en = 1'b1;
    step();
    bus.pix_en = 1'b0;
    checks++; if (bus.cell_rd_en !== 1'b0) begin errors++; $display("FAIL wait_rd_en got=%b exp=0", bus.cell_rd_en); end
    step();
    checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL wait_pix_valid got=%b exp=1", bus.pix_valid); end
    checks++; if (bus.color_in !== C_BLANK) begin errors++; $display("FAIL wait_color got=%h exp=%h", bus.color_in, C_BLANK); end
    checks++; if (bus.x_position !== 5'd0) begin errors++; $display("FAIL wait_x got=%0d exp=0", bus.x_position); end
    step();
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL wait_idle_valid got=%b exp=0", bus.pix_valid); end
  endtask

  task automatic test_first_line();
    start_frame();
    for (int c = 0; c < 24; c++) begin
      bus.pix_en = (c < 21);
      step();
      checks++;
      if (bus.cell_rd_en !== logic'(c < 21)) begin errors++; $display("FAIL line_rd_en c=%0d got=%b exp=%b", c, bus.cell_rd_en, c < 21); end
      if (c < 21) begin
        checks++;
        if (bus.cell_addr !== AW'(c < 20 ? 0 : 1)) begin errors++; $display("FAIL line_addr c=%0d got=%0d exp=%0d", c, bus.cell_addr, c < 20 ? 0 : 1); end
      end
      checks++;
      if (bus.pix_valid !== logic'(c >= 1 && c <= 21)) begin errors++; $display("FAIL line_valid c=%0d got=%b", c, bus.pix_valid); end
      if (c >= 1 && c <= 21) begin
        int p, ex;
        p  = c - 1;
        ex = (p < 20) ? p : 0;
        checks++; if (bus.x_position !== 5'(ex)) begin errors++; $display("FAIL line_x p=%0d got=%0d exp=%0d", p, bus.x_position, ex); end
        checks++; if (bus.y_position !== 5'd0) begin errors++; $display("FAIL line_y p=%0d got=%0d exp=0", p, bus.y_position); end
        checks++;
        if (bus.color_in !== exp_color(ex, 0, p < 20)) begin errors++; $display("FAIL line_color p=%0d got=%h exp=%h", p, bus.color_in, exp_color(ex, 0, p < 20)); end
      end
    end
    bus.pix_en = 1'b0;
  endtask

  task automatic test_same_cycle();
    start_frame();
    bus.pix_en = 1'b1;
    repeat (3) step();
    bus.line_end = 1'b1;
    step();
    bus.line_end = 1'b0;
    checks++; if (bus.cell_addr !== 10'd0) begin errors++; $display("FAIL same_addr got=%0d exp=0", bus.cell_addr); end
    step();
    bus.pix_en = 1'b0;
    checks++; if (bus.x_position !== 5'd3) begin errors++; $display("FAIL same_pre_x got=%0d exp=3", bus.x_position); end
    checks++; if (bus.y_position !== 5'd0) begin errors++; $display("FAIL same_pre_y got=%0d exp=0", bus.y_position); end
    step();
    checks++; if (bus.x_position !== 5'd0) begin errors++; $display("FAIL same_post_x got=%0d exp=0", bus.x_position); end
    checks++; if (bus.y_position !== 5'd1) begin errors++; $display("FAIL same_post_y got=%0d exp=1", bus.y_position); end
    checks++; if (bus.color_in !== exp_color(0, 1, 1'b1)) begin errors++; $display("FAIL same_post_color got=%h exp=%h", bus.color_in, exp_color(0, 1, 1'b1)); end
  endtask

  task automatic test_line_advance();
    start_frame();
    bus.line_end = 1'b1;
    repeat (5) step();
    bus.line_end = 1'b0;
    bus.pix_en = 1'b1;
    step();
    bus.pix_en = 1'b0;
    checks++; if (bus.cell_addr !== 10'd0) begin errors++; $display("FAIL adv5_addr got=%0d exp=0", bus.cell_addr); end
    step();
    checks++; if (bus.y_position !== 5'd5) begin errors++; $display("FAIL adv5_y got=%0d exp=5", bus.y_position); end
    checks++; if (bus.color_in !== exp_color(0, 5, 1'b1)) begin errors++; $display("FAIL grid_color got=%h exp=%h", bus.color_in, exp_color(0, 5, 1'b1)); end
    bus.line_end = 1'b1;
    repeat (15) step();
    bus.line_end = 1'b0;
    bus.pix_en = 1'b1;
    step();
    bus.pix_en = 1'b0;
    checks++; if (bus.cell_addr !== 10'(GC)) begin errors++; $display("FAIL adv20_addr got=%0d exp=%0d", bus.cell_addr, GC); end
    step();
    checks++; if (bus.y_position !== 5'd0) begin errors++; $display("FAIL adv20_y got=%0d exp=0", bus.y_position); end
    checks++; if (bus.color_in !== exp_color(0, 0, 1'b1)) begin errors++; $display("FAIL adv20_color got=%h exp=%h", bus.color_in, exp_color(0, 0, 1'b1)); end
  endtask

  task automatic test_frame_start_mid();
    bus.line_end = 1'b1;
    repeat (5) step();
    bus.frame_start = 1'b1; bus.line_end = 1'b1; bus.pix_en = 1'b1;
    step();
    bus.frame_start = 1'b0; bus.line_end = 1'b0; bus.pix_en = 1'b0;
    checks++; if (bus.cell_rd_en !== 1'b0) begin errors++; $display("FAIL fsmid_rd_en got=%b exp=0", bus.cell_rd_en); end
    step();
    checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL fsmid_valid got=%b exp=1", bus.pix_valid); end
    checks++; if (bus.color_in !== C_BLANK) begin errors++; $display("FAIL fsmid_color got=%h exp=%h", bus.color_in, C_BLANK); end
    bus.pix_en = 1'b1;
    step();
    bus.pix_en = 1'b0;
    checks++; if (bus.cell_rd_en !== 1'b1) begin errors++; $display("FAIL fsmid_next_rd got=%b exp=1", bus.cell_rd_en); end
    checks++; if (bus.cell_addr !== 10'd0) begin errors++; $display("FAIL fsmid_next_addr got=%0d exp=0", bus.cell_addr); end
    step();
    checks++; if (bus.y_position !== 5'd0) begin errors++; $display("FAIL fsmid_next_y got=%0d exp=0", bus.y_position); end
    checks++; if (bus.x_position !== 5'd0) begin errors++; $display("FAIL fsmid_next_x got=%0d exp=0", bus.x_position); end
  endtask

  task automatic test_col_saturate();
    start_frame();
    bus.pix_en = 1'b1;
    repeat (GC * BS) step();
    checks++; if (bus.cell_addr !== 10'(GC - 1)) begin errors++; $display("FAIL sat_last_addr got=%0d exp=%0d", bus.cell_addr, GC - 1); end
    step();
    bus.pix_en = 1'b0;
    checks++; if (bus.cell_rd_en !== 1'b0) begin errors++; $display("FAIL sat_rd_en got=%b exp=0", bus.cell_rd_en); end
    checks++; if (bus.x_position !== 5'(BS - 1)) begin errors++; $display("FAIL sat_last_x got=%0d exp=%0d", bus.x_position, BS - 1); end
    checks++; if (bus.color_in !== exp_color(BS - 1, 0, 1'b0)) begin errors++; $display("FAIL sat_last_color got=%h exp=%h", bus.color_in, exp_color(BS - 1, 0, 1'b0)); end
    step();
    checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got=%b exp=1", bus.pix_valid); end
    checks++; if (bus.color_in !== C_BLANK) begin errors++; $display("FAIL sat_color got=%h exp=%h", bus.color_in, C_BLANK); end
    checks++; if (bus.x_position !== 5'd0) begin errors++; $display("FAIL sat_x got=%0d exp=0", bus.x_position); end
  endtask

  task automatic test_done();
    start_frame();
    bus.line_end = 1'b1;
    repeat (GR * BS - 1) step();
    bus.line_end = 1'b0;
    bus.pix_en = 1'b1;
    step();
    bus.pix_en = 1'b0;
    checks++; if (bus.cell_addr !== 10'((GR - 1) * GC)) begin errors++; $display("FAIL done_last_addr got=%0d exp=%0d", bus.cell_addr, (GR - 1) * GC); end
    step();
    checks++; if (bus.y_position !== 5'(BS - 1)) begin errors++; $display("FAIL done_last_y got=%0d exp=%0d", bus.y_position, BS - 1); end
    checks++; if (bus.color_in !== exp_color(0, BS - 1, 1'b1)) begin errors++; $display("FAIL done_last_color got=%h exp=%h", bus.color_in, exp_color(0, BS - 1, 1'b1)); end
    bus.line_end = 1'b1;
    step();
    bus.line_end = 1'b0;
    bus.pix_en = 1'b1;
    step();
    bus.pix_en = 1'b0;
    checks++; if (bus.cell_rd_en !== 1'b0) begin errors++; $display("FAIL done_rd_en got=%b exp=0", bus.cell_rd_en); end
    step();
    checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL done_valid got=%b exp=1", bus.pix_valid); end
    checks++; if (bus.color_in !== C_BLANK) begin errors++; $display("FAIL done_color got=%h exp=%h", bus.color_in, C_BLANK); end
    checks++; if (bus.y_position !== 5'd0) begin errors++; $display("FAIL done_y got=%0d exp=0", bus.y_position); end
  endtask

  task automatic test_reset_midflight();
    start_frame();
    bus.pix_en = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.cell_rd_en !== 1'b0) begin errors++; $display("FAIL async_rd_en got=%b exp=0", bus.cell_rd_en); end
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b exp=0", bus.pix_valid); end
    checks++; if (bus.color_in !== 8'h00) begin errors++; $display("FAIL async_color got=%h exp=00", bus.color_in); end
    bus.pix_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", bus.pix_valid); end
    checks++; if (bus.cell_rd_en !== 1'b0) begin errors++; $display("FAIL post_reset_rd_en got=%b exp=0", bus.cell_rd_en); end
  endtask

  initial begin
    test_reset();
    test_wait_frame();
    test_first_line();
    test_same_cycle();
    test_line_advance();
    test_frame_start_mid();
    test_col_saturate();
    test_done();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cell_scan_sequencer.md
CELL_SCAN_SEQUENCER -- requirements
Module: cell_scan_sequencer

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 20, cell edge in pixels (2..31).
REQ-002 SHALL have parameter GRID_COLS, default 32, cells per grid row.
REQ-003 SHALL have parameter GRID_ROWS, default 24, cell rows per frame.
REQ-004 SHALL have parameter ADDR_W, default 10, cell memory address width (at least clog2(GRID_COLS*GRID_ROWS)).
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frame_start  in  1  one-cycle pulse before the first active pixel of a frame.
REQ-008 line_end  in  1  one-cycle pulse after the last active pixel of a line.
REQ-009 pix_en  in  1  one active display pixel this cycle.
REQ-010 cell_rd_en  out  1  cell memory read strobe.
REQ-011 cell_addr  out  ADDR_W  cell memory address, row*GRID_COLS+col.
REQ-012 cell_data  in  1  cell alive bit, valid the cycle after cell_rd_en.
REQ-013 color_alive, color_dead, color_blank  in  8 each  palette.
REQ-014 x_position, y_position  out  5 each  pixel offset inside the current cell, to the circle renderer.
REQ-015 color_in  out  8  cell color to the circle renderer.
REQ-016 pix_valid  out  1  outputs above carry a pixel.

Function
REQ-017 States: WAIT_FRAME, SCAN, DONE; reset state WAIT_FRAME.
REQ-018 frame_start in any state: col, row, x_cnt, y_cnt cleared to 0; state to SCAN next cycle.
REQ-019 SCAN, pix_en: x_cnt increments; at BLOCK_SIZE-1 it wraps to 0 and col increments.
REQ-020 SCAN, line_end: col and x_cnt cleared; y_cnt increments; at BLOCK_SIZE-1 it wraps to 0 and row increments; row reaching GRID_ROWS moves state to DONE.
REQ-021 pix_en with line_end same cycle: pixel processed with pre-update counters, then line advance applied.
REQ-022 frame_start with line_end or pix_en same cycle: frame_start wins; the pixel is output as blank.
REQ-023 Pipeline stage 1 (cycle after pix_en): cell_rd_en=1, cell_addr=row*GRID_COLS+col, x_cnt/y_cnt registered; only when in SCAN and col<GRID_COLS.
REQ-024 Stage 2 (two cycles after pix_en): pix_valid=1; x_position/y_position = registered counters; color_in = color_alive if cell_data=1 else color_dead.
REQ-025 pix_en in WAIT_FRAME or DONE, or with col>=GRID_COLS: cell_rd_en=0; stage 2 outputs pix_valid=1, color_in=color_blank, x_position=y_position=0; counters hold (col saturates at GRID_COLS).
REQ-026 Latency fixed at 2 cycles, one pixel per cycle, no stalls; back-to-back pix_en fully pipelined.
REQ-027 No pix_en: pix_valid=0 two cycles later; cell_rd_en=0 next cycle.
REQ-028 Address arithmetic in ADDR_W bits, no wrap within legal grid.

Reset
REQ-029 rst_n low: state WAIT_FRAME; counters, pipeline registers, cell_rd_en, cell_addr, pix_valid, x_position, y_position, color_in all 0 immediately.
REQ-030 Reset mid-frame discards in-flight pixels; nothing output until pix_en after release.

Configuration
REQ-031 Macro CELL_GRID_LINES_EN: when defined, stage-2 pixels with x_position=0 or y_position=0 output color_blank regardless of cell_data; when undefined, no grid override (REQ-024 only).

Verification
REQ-032 Reset, frame_start, 20 pix_en, cell_data=1 -> cell_rd_en on cycles 1..20 with cell_addr=0, pix_valid cycles 2..21, x_position 0..19, color_in=color_alive.
REQ-033 21st pix_en in the same line -> cell_addr=1, x_position=0.
REQ-034 20 line_end pulses after frame_start -> next pixel reads cell_addr=GRID_COLS (32), y_position=0.
REQ-035 GRID_ROWS*BLOCK_SIZE lines then pix_en -> DONE, cell_rd_en=0, color_in=color_blank.
REQ-036 frame_start and line_end same cycle mid-frame -> row=0, y_cnt=0, next pixel reads addr 0.
REQ-037 CELL_GRID_LINES_EN defined, pixel (0,5) of alive cell -> color_blank; undefined -> color_alive.
